fb_port_arbiter: RTL and testbench

- Shares the single-port frame buffer BRAM (320x240 pixels, 17-bit address) between three requesters:
  - the display pixel-address path (mirror/scale address generator output),
  - camera pixel writes,
  - a processing-engine read port.
- Display reads have strict priority and can never stall.
- Camera writes are absorbed in a small FIFO and drained in idle slots. The engine reads through a valid/ready handshake.
- Sits between the address generators and the BRAM instance in the top level.

---
 rtl/fb_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_fb_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares the single-port frame buffer BRAM between display reads,
// buffered camera writes and engine reads. Display has strict priority.
`default_nettype none

module fb_port_arbiter #(
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 76800,
  parameter int RD_LAT      = 2,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           disp_valid_in,
  input  logic [ADDR_W-1:0]              disp_addr_in,
  output logic [DATA_W-1:0]              disp_data_out,
  output logic                           disp_valid_out,
  input  logic                           cam_valid_in,
  input  logic [ADDR_W-1:0]              cam_addr_in,
  input  logic [DATA_W-1:0]              cam_data_in,
  input  logic                           eng_valid_in,
  input  logic [ADDR_W-1:0]              eng_addr_in,
  output logic                           eng_ready_out,
  output logic [DATA_W-1:0]              eng_data_out,
  output logic                           eng_valid_out,
  output logic [ADDR_W-1:0]              bram_addr_out,
  output logic [DATA_W-1:0]              bram_din_out,
  output logic                           bram_we_out,
  input  logic [DATA_W-1:0]              bram_dout_in,
  output logic [$clog2(WFIFO_DEPTH):0]   wfifo_count_out,
  output logic                           wfifo_overflow_out
);

  localparam int PTR_W = $clog2(WFIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(WFIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, DISP = 2'd1, WR = 2'd2, ENG = 2'd3} grant_t;

  logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [WFIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  grant_t            grant_d, grant_q;
  logic              oob_q;
  logic [2:0]        tag0;
  logic [2:0]        tag_pipe [1:RD_LAT];

  logic              fifo_empty, fifo_full;
  logic              push_req, push, pop;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_oob;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign push_req   = cam_valid_in & ({1'b0, cam_addr_in} < DEPTH_LIM);
  assign pop        = (grant_d == WR);
  // A full FIFO still accepts a write when the head drains in the same cycle.
  assign push       = push_req & (~fifo_full | pop);

  assign rd_addr       = disp_valid_in ? disp_addr_in : eng_addr_in;
  assign rd_oob        = ({1'b0, rd_addr} >= DEPTH_LIM);
  assign eng_ready_out = eng_valid_in & ~disp_valid_in & fifo_empty;

  always_comb begin
    grant_d = IDLE;
    if (disp_valid_in)     grant_d = DISP;
    else if (!fifo_empty)  grant_d = WR;
    else if (eng_valid_in) grant_d = ENG;
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cam_addr_in;
      fifo_data[wr_ptr] <= cam_data_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      grant_q       <= IDLE;
      oob_q         <= 1'b0;
      bram_addr_out <= '0;
      bram_din_out  <= '0;
      bram_we_out   <= 1'b0;
    end else begin
      grant_q <= grant_d;
      case (grant_d)
        DISP, ENG: begin
          bram_addr_out <= rd_addr;
          bram_we_out   <= 1'b0;
          oob_q         <= rd_oob;
        end
        WR: begin
          bram_addr_out <= fifo_addr[rd_ptr];
          bram_din_out  <= fifo_data[rd_ptr];
          bram_we_out   <= 1'b1;
          oob_q         <= 1'b0;
        end
        default: begin
          bram_we_out <= 1'b0;
          oob_q       <= 1'b0;
        end
      endcase
    end
  end

  // Stage 0 of the return tag is the registered grant itself; RD_LAT more stages follow.
  assign tag0 = {grant_q == DISP, grant_q == ENG, oob_q};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int k = 1; k <= RD_LAT; k++) tag_pipe[k] <= 3'b000;
    end else begin
      for (int k = RD_LAT; k > 1; k--) tag_pipe[k] <= tag_pipe[k-1];
      tag_pipe[1] <= tag0;
    end
  end

  assign disp_valid_out     = tag_pipe[RD_LAT][2];
  assign eng_valid_out      = tag_pipe[RD_LAT][1];
  assign disp_data_out      = (disp_valid_out && !tag_pipe[RD_LAT][0]) ? bram_dout_in : '0;
  assign eng_data_out       = (eng_valid_out  && !tag_pipe[RD_LAT][0]) ? bram_dout_in : '0;
  assign wfifo_count_out    = count;
  assign wfifo_overflow_out = overflow;

endmodule

`default_nettype wire

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed self-checking bench with a 2-cycle BRAM model.
`default_nettype none

module tb_fb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_valid;
  logic [16:0] disp_addr;
  logic [15:0] disp_data;
  logic        disp_valid_o;
  logic        cam_valid;
  logic [16:0] cam_addr;
  logic [15:0] cam_data;
  logic        eng_valid;
  logic [16:0] eng_addr;
  logic        eng_ready;
  logic [15:0] eng_data;
  logic        eng_valid_o;
  logic [16:0] bram_addr;
  logic [15:0] bram_din;
  logic        bram_we;
  logic [15:0] bram_dout;
  logic [2:0]  wcount;
  logic        wovf;

  int checks = 0;
  int failures = 0;

  fb_port_arbiter dut (
    .clk_in(clk), .rst_in(rst),
    .disp_valid_in(disp_valid), .disp_addr_in(disp_addr),
    .disp_data_out(disp_data), .disp_valid_out(disp_valid_o),
    .cam_valid_in(cam_valid), .cam_addr_in(cam_addr), .cam_data_in(cam_data),
    .eng_valid_in(eng_valid), .eng_addr_in(eng_addr), .eng_ready_out(eng_ready),
    .eng_data_out(eng_data), .eng_valid_out(eng_valid_o),
    .bram_addr_out(bram_addr), .bram_din_out(bram_din), .bram_we_out(bram_we),
    .bram_dout_in(bram_dout),
    .wfifo_count_out(wcount), .wfifo_overflow_out(wovf)
  );

  always #5 clk = ~clk;

  // BRAM model: unwritten locations read as (addr[7:0] + 100), latency 2 from registered address.
  logic        written [256];
  logic [15:0] wdata   [256];
  logic [15:0] rd_stage;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) written[k] <= 1'b0;
      rd_stage  <= '0;
      bram_dout <= '0;
    end else begin
      rd_stage  <= written[bram_addr[7:0]] ? wdata[bram_addr[7:0]]
                                          : 16'(bram_addr[7:0]) + 16'd100;
      bram_dout <= rd_stage;
      if (bram_we) begin
        written[bram_addr[7:0]] <= 1'b1;
        wdata[bram_addr[7:0]]   <= bram_din;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    disp_valid = 1'b0; disp_addr = '0;
    cam_valid  = 1'b0; cam_addr  = '0; cam_data = '0;
    eng_valid  = 1'b0; eng_addr  = '0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    #1;
    check("rst_we", bram_we, 0);
    check("rst_addr", bram_addr, 0);
    check("rst_count", wcount, 0);
    check("rst_ovf", wovf, 0);
    check("rst_dvalid", disp_valid_o, 0);
    check("rst_evalid", eng_valid_o, 0);
    rst = 1'b0;
    tick();

    // Reset while a display read and a buffered write are in flight.
    disp_valid = 1'b1; disp_addr = 17'd3;
    cam_valid = 1'b1; cam_addr = 17'd9; cam_data = 16'h0001;
    tick();
    clear_inputs();
    rst = 1'b1;
    #1;
    check("midrst_we", bram_we, 0);
    check("midrst_count", wcount, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("midrst_dvalid", disp_valid_o, 0);
      tick();
    end

    // Back-to-back display reads of 0,1,2.
    for (int i = 0; i < 7; i++) begin
      disp_valid = (i < 3);
      disp_addr  = 17'(i);
      #1;
      if (i >= 3) begin
        check("disp_valid", disp_valid_o, (i < 6));
        if (i < 6) check("disp_data", disp_data, 100 + i - 3);
      end
      tick();
    end

    // Single camera write drains in an idle slot, then is read back.
    cam_valid = 1'b1; cam_addr = 17'd5; cam_data = 16'hABCD;
    tick();
    clear_inputs();
    #1;
    check("wr_count1", wcount, 1);
    tick();
    #1;
    check("wr_we", bram_we, 1);
    check("wr_addr", bram_addr, 5);
    check("wr_din", bram_din, 16'hABCD);
    check("wr_count0", wcount, 0);
    tick();
    disp_valid = 1'b1; disp_addr = 17'd5;
    #1;
    check("wr_we_off", bram_we, 0);
    tick();
    disp_valid = 1'b0;
    tick(); tick();
    #1;
    check("rb_valid", disp_valid_o, 1);
    check("rb_data", disp_data, 16'hABCD);
    tick();

    // Overflow under a display burst, then in-order drain.
    for (int i = 0; i < 5; i++) begin
      disp_valid = 1'b1; disp_addr = '0;
      cam_valid = 1'b1; cam_addr = 17'(20 + i); cam_data = 16'(16'h1000 + i);
      #1;
      if (i > 0) check("ovf_count", wcount, i);
      if (i == 4) check("ovf_pre", wovf, 0);
      tick();
    end
    clear_inputs();
    #1;
    check("ovf_count_full", wcount, 4);
    check("ovf_set", wovf, 1);
    tick();
    for (int j = 0; j < 4; j++) begin
      #1;
      check("drain_we", bram_we, 1);
      check("drain_addr", bram_addr, 20 + j);
      check("drain_din", bram_din, 16'h1000 + j);
      check("drain_count", wcount, 3 - j);
      tick();
    end
    #1;
    check("drain_done_we", bram_we, 0);
    check("ovf_sticky", wovf, 1);

    // Engine waits out a display burst.
    for (int i = 0; i < 3; i++) begin
      disp_valid = 1'b1; disp_addr = 17'd1;
      eng_valid = 1'b1; eng_addr = 17'd7;
      #1;
      check("eng_ready_blocked", eng_ready, 0);
      tick();
    end
    disp_valid = 1'b0;
    #1;
    check("eng_ready_go", eng_ready, 1);
    tick();
    eng_valid = 1'b0;
    #1;
    check("eng_valid_early", eng_valid_o, 0);
    tick();
    #1;
    check("eng_valid_early2", eng_valid_o, 0);
    tick();
    #1;
    check("eng_valid", eng_valid_o, 1);
    check("eng_data", eng_data, 107);
    tick();
    #1;
    check("eng_valid_pulse", eng_valid_o, 0);

    // Out-of-range reads return zero with valid.
    eng_valid = 1'b1; eng_addr = 17'd76800;
    #1;
    check("eng_oob_ready", eng_ready, 1);
    tick();
    eng_valid = 1'b0;
    tick(); tick();
    #1;
    check("eng_oob_valid", eng_valid_o, 1);
    check("eng_oob_data", eng_data, 0);
    tick();
    disp_valid = 1'b1; disp_addr = 17'd76801;
    tick();
    disp_valid = 1'b0;
    tick(); tick();
    #1;
    check("disp_oob_valid", disp_valid_o, 1);
    check("disp_oob_data", disp_data, 0);
    tick();

    // Out-of-range camera write is discarded.
    cam_valid = 1'b1; cam_addr = 17'd76800; cam_data = 16'h5555;
    tick();
    clear_inputs();
    #1;
    check("cam_oob_count", wcount, 0);
    tick();
    #1;
    check("cam_oob_we", bram_we, 0);

    // Full FIFO with simultaneous push and pop.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst2_ovf", wovf, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      disp_valid = 1'b1; disp_addr = '0;
      cam_valid = 1'b1; cam_addr = 17'(40 + i); cam_data = 16'(16'h2000 + i);
      tick();
    end
    disp_valid = 1'b0;
    cam_valid = 1'b1; cam_addr = 17'd44; cam_data = 16'h2004;
    #1;
    check("pp_full", wcount, 4);
    tick();
    clear_inputs();
    #1;
    check("pp_count", wcount, 4);
    check("pp_ovf", wovf, 0);
    check("pp_we", bram_we, 1);
    check("pp_addr", bram_addr, 40);
    tick();
    for (int j = 1; j < 5; j++) begin
      #1;
      check("pp_drain_addr", bram_addr, 40 + j);
      check("pp_drain_din", bram_din, 16'h2000 + j);
      tick();
    end
    #1;
    check("pp_count_end", wcount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
